// File: rtl/regfile_sb.sv
// Multi-read-port register file with integrated busy-bit scoreboard; r0 is hardwired zero.
// Optional macro REGFILE_SB_BYPASS_EN forwards a same-cycle write to matching read ports.
`timescale 1ns/1ps
module regfile_sb #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NRD   = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH)-1:0]       wr_addr,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           wr_clr,
   input  logic                           iss_en,
   input  logic [$clog2(DEPTH)-1:0]       iss_addr,
   input  logic [NRD*$clog2(DEPTH)-1:0]   rd_addr,
   output logic [NRD*WIDTH-1:0]           rd_data,
   output logic [NRD-1:0]                 rd_busy,
   output logic [DEPTH-1:0]               busy_vec,
   output logic                           iss_hazard
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            mem[r] <= '0;
         end
      end else if (wr_en && wr_addr != '0) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Set is applied after clear so a same-cycle issue keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (wr_en && wr_clr) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (iss_en) begin
         busy_nxt[iss_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   always_comb begin
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;
      logic             b;
      rd_data = '0;
      rd_busy = '0;
      a       = '0;
      d       = '0;
      b       = 1'b0;
      for (int unsigned i = 0; i < NRD; i++) begin
         a = rd_addr[i*AW +: AW];
         d = mem[a];
         b = busy[a];
`ifdef REGFILE_SB_BYPASS_EN
         // rst_n gate keeps outputs at zero while reset is held.
         if (rst_n && wr_en && wr_addr == a && wr_addr != '0) begin
            d = wr_data;
            b = busy[wr_addr] & ~wr_clr;
         end
`endif
         rd_data[i*WIDTH +: WIDTH] = d;
         rd_busy[i]                = b;
      end
   end

   assign busy_vec   = busy;
   assign iss_hazard = busy[iss_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (WIDTH=64, DEPTH=16, NRD=4): directed cases plus random
// traffic checked against an array-based model; follows REGFILE_SB_BYPASS_EN if defined.
`timescale 1ns/1ps
module tb_regfile_sb;

   localparam int W  = 64;
   localparam int D  = 16;
   localparam int NP = 4;
   localparam int AW = $clog2(D);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [W-1:0]      wr_data;
   logic              wr_clr;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic [NP*AW-1:0]  rd_addr;
   logic [NP*W-1:0]   rd_data;
   logic [NP-1:0]     rd_busy;
   logic [D-1:0]      busy_vec;
   logic              iss_hazard;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] m_data [D];
   bit           m_busy [D];

   regfile_sb #(.WIDTH(W), .DEPTH(D), .NRD(NP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_clr     (wr_clr),
      .iss_en     (iss_en),
      .iss_addr   (iss_addr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .busy_vec   (busy_vec),
      .iss_hazard (iss_hazard)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_clr   = 1'b0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   task automatic set_rd(input int p, input int a);
      logic [AW-1:0] av;
      av = a[AW-1:0];
      rd_addr[p*AW +: AW] = av;
   endtask

   function automatic int port_addr(input int p);
      logic [AW-1:0] av;
      av = rd_addr[p*AW +: AW];
      return int'(av);
   endfunction

   function automatic logic [W-1:0] val(input int r);
      logic [31:0] rv;
      rv = 32'(r);
      return {rv * 32'h0101_0101, ~(rv * 32'h0011_0011)};
   endfunction

   task automatic model_reset();
      for (int r = 0; r < D; r++) begin
         m_data[r] = '0;
         m_busy[r] = 1'b0;
      end
   endtask

   // What a read port must show given the stored model state and the inputs of this cycle.
   task automatic model_read(input int a, output logic [W-1:0] d, output logic b);
      d = (a == 0) ? '0 : m_data[a];
      b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && a != 0 && int'(wr_addr) == a) begin
         d = wr_data;
         b = m_busy[a] && !wr_clr;
      end
`endif
   endtask

   task automatic model_update();
      if (wr_en && wr_addr != 0) m_data[wr_addr] = wr_data;
      if (wr_en && wr_clr) m_busy[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
   endtask

   task automatic check_all();
      logic [W-1:0] ed;
      logic         eb;
      logic [D-1:0] ev;
      for (int p = 0; p < NP; p++) begin
         model_read(port_addr(p), ed, eb);
         check($sformatf("rd_data%0d", p), rd_data[p*W +: W], ed);
         check($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(eb));
      end
      for (int r = 0; r < D; r++) ev[r] = m_busy[r];
      check("busy_vec", 64'(busy_vec), 64'(ev));
      check("iss_hazard", 64'(iss_hazard), 64'(m_busy[iss_addr]));
   endtask

   // Called one time unit after a rising edge; returns at the same phase of the next cycle.
   task automatic cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      rd_addr = '0;
      idle();
      model_reset();
      #1;
      check("reset_rd_data", 64'(rd_data[W-1:0]), 64'h0);
      check("reset_busy_vec", 64'(busy_vec), 64'h0);
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset asserted mid-run discards data and pending marks.
      idle(); wr_en = 1'b1; wr_addr = 5; wr_data = 64'hDEAD_BEEF; cycle();
      idle(); iss_en = 1'b1; iss_addr = 7; cycle();
      idle(); set_rd(0, 5); set_rd(1, 7); set_rd(2, 5); set_rd(3, 7); cycle();
      rst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 5; wr_data = 64'h1111; iss_en = 1'b1; iss_addr = 7;
      #1;
      check("rst_rd_data_r5", 64'(rd_data[0 +: W]), 64'h0);
      check("rst_rd_data_r7", 64'(rd_data[W +: W]), 64'h0);
      check("rst_rd_busy", 64'(rd_busy), 64'h0);
      check("rst_busy_vec", 64'(busy_vec), 64'h0);
      check("rst_iss_hazard", 64'(iss_hazard), 64'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      @(posedge clk);
      #1;
      cycle();

      // Register 0 ignores writes and issues.
      idle(); wr_en = 1'b1; wr_addr = 0; wr_data = '1; iss_en = 1'b1; iss_addr = 0; cycle();
      idle(); for (int p = 0; p < NP; p++) set_rd(p, 0);
      #1;
      for (int p = 0; p < NP; p++) check("r0_data", rd_data[p*W +: W], 64'h0);
      check("r0_busy", 64'(rd_busy), 64'h0);
      check("r0_busy_vec", 64'(busy_vec[0]), 64'h0);
      cycle();

      // Issue, hazard, then clearing write.
      idle(); iss_en = 1'b1; iss_addr = 3; cycle();
      idle(); set_rd(2, 3); iss_en = 1'b1; iss_addr = 3;
      #1;
      check("flow_busy_vec3", 64'(busy_vec[3]), 64'h1);
      check("flow_rd_busy2", 64'(rd_busy[2]), 64'h1);
      check("flow_iss_hazard", 64'(iss_hazard), 64'h1);
      cycle();
      idle(); wr_en = 1'b1; wr_addr = 3; wr_data = 64'h1234_5678; wr_clr = 1'b1; cycle();
      idle(); for (int p = 0; p < NP; p++) set_rd(p, 3);
      #1;
      for (int p = 0; p < NP; p++) check("flow_data", rd_data[p*W +: W], 64'h1234_5678);
      check("flow_rd_busy", 64'(rd_busy), 64'h0);
      cycle();

      // Same-cycle set and clear: set wins.
      idle(); iss_en = 1'b1; iss_addr = 9; cycle();
      idle(); wr_en = 1'b1; wr_addr = 9; wr_data = 64'hA5; wr_clr = 1'b1;
      iss_en = 1'b1; iss_addr = 9; cycle();
      idle(); set_rd(0, 9);
      #1;
      check("setclr_data", rd_data[0 +: W], 64'hA5);
      check("setclr_busy_vec9", 64'(busy_vec[9]), 64'h1);
      cycle();

      // Write forwarding (or its absence) on a clearing write.
      idle(); wr_en = 1'b1; wr_addr = 4; wr_data = 64'h1; iss_en = 1'b1; iss_addr = 4; cycle();
      idle(); wr_en = 1'b1; wr_addr = 4; wr_data = 64'h2; wr_clr = 1'b1; set_rd(0, 4);
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      check("byp_same_data", rd_data[0 +: W], 64'h2);
      check("byp_same_busy", 64'(rd_busy[0]), 64'h0);
`else
      check("byp_same_data", rd_data[0 +: W], 64'h1);
      check("byp_same_busy", 64'(rd_busy[0]), 64'h1);
`endif
      cycle();
      idle(); set_rd(0, 4);
      #1;
      check("byp_next_data", rd_data[0 +: W], 64'h2);
      check("byp_next_busy", 64'(rd_busy[0]), 64'h0);
      cycle();

      // Distinct 64-bit values everywhere, four ports on different registers.
      for (int r = 1; r < D; r++) begin
         idle(); wr_en = 1'b1; wr_addr = r[AW-1:0]; wr_data = val(r); cycle();
      end
      idle(); set_rd(0, 15); set_rd(1, 1); set_rd(2, 8); set_rd(3, 3);
      #1;
      check("par_p0_r15", rd_data[0 +: W], val(15));
      check("par_p1_r1", rd_data[W +: W], val(1));
      check("par_p2_r8", rd_data[2*W +: W], val(8));
      check("par_p3_r3", rd_data[3*W +: W], val(3));
      cycle();
      idle(); set_rd(0, 14); set_rd(1, 15); set_rd(2, 0); set_rd(3, 7); cycle();

      // Random traffic, addresses biased toward a few registers to provoke collisions.
      for (int n = 0; n < 600; n++) begin
         int hot;
         hot = ($urandom_range(0, 1) == 1) ? 7 : D - 1;
         wr_en    = ($urandom_range(0, 2) != 0);
         wr_addr  = AW'($urandom_range(0, hot));
         wr_data  = {$urandom, $urandom};
         wr_clr   = ($urandom_range(0, 1) == 1);
         iss_en   = ($urandom_range(0, 1) == 1);
         iss_addr = AW'($urandom_range(0, hot));
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 3) == 0) set_rd(p, int'(wr_addr));
            else set_rd(p, int'($urandom_range(0, hot)));
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with an integrated busy-bit scoreboard, the successor to the fixed 32x32 two-read-port register file. Sits between decode/issue and writeback in the pipelined core. Issue marks destination registers pending. Writeback stores results and clears the pending marks. Read ports return data plus a per-port busy flag, so decode can detect RAW hazards without a separate scoreboard block.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; power of two, ≥2; localparam AW = $clog2(DEPTH)
- NRD, 2, number of read ports, ≥1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write wr_data to wr_addr this cycle
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- wr_clr  in  1  qualified by wr_en; also clear busy bit of wr_addr
- iss_en  in  1  mark iss_addr busy this cycle
- iss_addr  in  AW  destination index being issued
- rd_addr  in  NRD*AW  port i address at [i*AW +: AW]
- rd_data  out  NRD*WIDTH  port i data at [i*WIDTH +: WIDTH]
- rd_busy  out  NRD  port i: addressed register has a pending write
- busy_vec  out  DEPTH  raw scoreboard state, bit r = register r
- iss_hazard  out  1  iss_addr is currently busy (WAW), combinational

## Operation
- Register 0 is hardwired zero.
  - Reads of register 0 return 0 with rd_busy = 0.
  - Writes to register 0 are ignored.
  - Issue to register 0 is ignored; busy_vec[0] is always 0.
- Write: at posedge, if wr_en && wr_addr != 0, data[wr_addr] <= wr_data.
- Scoreboard next state, per register r != 0:
  - busy[r] <= (busy[r] & ~(wr_en & wr_clr & wr_addr == r)) | (iss_en & iss_addr == r).
  - When a set and a clear hit the same r in the same cycle, the set wins, because the new instruction owns the register.
- A clear of a non-busy register has no scoreboard effect; the write still happens.
- wr_clr without wr_en has no effect.
- Reads are combinational from the array and scoreboard: rd_data[i] = data[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]].
  - All ports are independent.
  - Any number of ports may address the same register.
- iss_hazard = busy[iss_addr] (0 for iss_addr 0), computed from current state only. The block never blocks an issue; stalling is decode's job.
- busy_vec reflects registered state only and is never bypassed.

## Timing
- Reset (rst_n low, asynchronous):
  - All data words and all busy bits are cleared to 0 immediately.
  - During reset, rd_data = 0, rd_busy = 0, busy_vec = 0 and iss_hazard = 0.
- Reset asserted mid-operation discards all pending marks and stored data. The first edge after deassertion behaves normally.
- Write-to-read latency is 1 cycle (0 with bypass, see Configuration).
- Issue-to-busy latency is 1 cycle: busy_vec and rd_busy show the mark after the issuing edge.
- Clear-to-not-busy latency is 1 cycle (0 for rd_busy with bypass).
- There is no handshake and no backpressure. Every input is sampled every cycle.

## Configuration
- REGFILE_SB_BYPASS_EN defined:
  - Same-cycle write forwarding applies to each read port i when wr_en && wr_addr == rd_addr[i] && wr_addr != 0.
  - In that case rd_data[i] = wr_data.
  - rd_busy[i] = busy[wr_addr] & ~wr_clr.
  - iss_hazard is not bypassed.
- REGFILE_SB_BYPASS_EN undefined:
  - Reads return stored data and raw busy state only.
  - A same-cycle write is visible the next cycle.

## Test plan
- Reset then read: assert rst_n=0 mid-run after writing 0xDEADBEEF to r5 and issuing r7. Read r5 and r7 → rd_data=0, rd_busy=0, busy_vec=0.
- Zero register: wr_en to r0 with 0xFFFFFFFF, and iss_en to r0 in the same cycle. Next cycle, read r0 on all ports → data 0, rd_busy 0, busy_vec[0]=0.
- Basic flow, NRD=3:
  - Cycle 0: issue r3.
  - Cycle 1: busy_vec[3]=1; port 2 reading r3 gives rd_busy=1; issuing r3 again gives iss_hazard=1.
  - Cycle 2: write 0x12345678 to r3 with wr_clr.
  - Cycle 3: all ports read 0x12345678, rd_busy=0.
- Simultaneous set/clear: r9 is busy; in the same cycle, wr_en+wr_clr to r9 with 0xA5 and iss_en r9. Next cycle → data[r9]=0xA5, busy_vec[9]=1.
- Bypass (macro defined): r4 holds 0x1 and is busy; wr_en+wr_clr r4 with 0x2, and port 0 reads r4 in the same cycle → rd_data=0x2, rd_busy=0. With the macro undefined the same cycle gives 0x1 and 1, and the next cycle gives 0x2 and 0.
- Parametrisation: WIDTH=64, DEPTH=16, NRD=4; write distinct values to r1..r15. All four ports read different registers simultaneously → each returns its own value; an AW=4 address of 15 maps correctly.
